ecc_error_logger: RTL and testbench

Downstream consumer of the 8-bit/4-parity Hamming decoder output. Samples each checked word (address, syndrome, corrected data) and classifies the error. Keeps saturating error counters and a small FIFO log of error events readable by software. Raises a sticky interrupt on uncorrectable errors or when the corrected-error count crosses a threshold.

---
 rtl/ecc_pkg.sv | 36 +++
 rtl/ecc_log_fifo.sv | 65 ++++++
 rtl/ecc_error_logger.sv | 140 ++++++++++++++
 tb/tb_ecc_error_logger.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared types and helpers for the ECC error logger: error classes,
// the fixed-width portion of a log entry, and the syndrome classifier.
package ecc_pkg;

    localparam int SYN_W  = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        NONE      = 2'b00,
        DATA_CORR = 2'b01,
        PAR_CORR  = 2'b10,
        UNCORR    = 2'b11
    } err_class_t;

    // Fixed-width fields of a log entry. The address width is a parameter of
    // the top level, so the address is appended below these fields there.
    typedef struct packed {
        err_class_t              cls;
        logic [SYN_W-1:0]        syndrome;
        logic [DATA_W-1:0]       data;
    } log_entry_t;

    // Map a Hamming(12,8) syndrome onto an error class. Single-bit syndromes
    // point at a parity bit, 13..15 do not correspond to any bit position.
    function automatic err_class_t classify_syndrome(input logic [SYN_W-1:0] syn);
        err_class_t cls;
        case (syn)
            4'd0:                    cls = NONE;
            4'd1, 4'd2, 4'd4, 4'd8:  cls = PAR_CORR;
            4'd13, 4'd14, 4'd15:     cls = UNCORR;
            default:                 cls = DATA_CORR;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ecc_log_fifo.sv
// Synchronous FIFO for error-log entries. A push into a full FIFO succeeds
// only when a pop frees a slot in the same cycle; otherwise it is dropped.
// The head word reads as zero while the FIFO is empty.
module ecc_log_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointer and occupancy values from the accepted push/pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Pointer and occupancy registers with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; stale words are unreachable because head is gated by empty.
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ecc_error_logger.sv
// ECC error logger: registers each decoder result, classifies its syndrome
// one edge later, keeps saturating per-class counters, logs non-clean
// events into a FIFO and raises a sticky interrupt.
module ecc_error_logger
    import ecc_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int LOG_DEPTH  = 8,
    parameter int CNT_W      = 16,
    parameter int IRQ_THRESH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       chk_valid,
    input  logic [ADDR_W-1:0]          chk_addr,
    input  logic [SYN_W-1:0]           chk_syndrome,
    input  logic [DATA_W-1:0]          chk_data,
    input  logic                       clr,
    input  logic                       log_rd_en,
    output logic                       log_empty,
    output logic [$clog2(LOG_DEPTH):0] log_count,
    output logic [ADDR_W+13:0]         log_entry,
    output logic                       log_overflow,
    output logic [CNT_W-1:0]           cnt_data_corr,
    output logic [CNT_W-1:0]           cnt_par_corr,
    output logic [CNT_W-1:0]           cnt_uncorr,
    output logic                       irq
);

    localparam int ENTRY_W = ADDR_W + $bits(log_entry_t);

    // Stage 1 registers.
    logic                s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0]   s1_addr_q,  s1_addr_d;
    logic [SYN_W-1:0]    s1_syn_q,   s1_syn_d;
    logic [DATA_W-1:0]   s1_data_q,  s1_data_d;

    // Stage 2 state.
    logic [CNT_W-1:0]    cnt_data_q, cnt_data_d;
    logic [CNT_W-1:0]    cnt_par_q,  cnt_par_d;
    logic [CNT_W-1:0]    cnt_unc_q,  cnt_unc_d;
    logic                ovf_q,      ovf_d;
    logic                irq_q,      irq_d;

    logic                sync_clr;
    err_class_t          s2_class;
    logic                s2_event;
    log_entry_t          s2_meta;
    logic [ENTRY_W-1:0]  push_data;
    logic [CNT_W:0]      corr_sum;
    logic                fifo_full;

    assign sync_clr = rst || clr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stage 1: capture the decoder result; invalid cycles leave no event.
    always_comb begin
        s1_valid_d = chk_valid;
        s1_addr_d  = chk_addr;
        s1_syn_d   = chk_syndrome;
        s1_data_d  = chk_data;
    end

    // Stage 2: classify, count, build the log word and evaluate the interrupt.
    always_comb begin
        s2_class         = classify_syndrome(s1_syn_q);
        s2_event         = s1_valid_q && (s2_class != NONE);
        s2_meta.cls      = s2_class;
        s2_meta.syndrome = s1_syn_q;
        s2_meta.data     = s1_data_q;
        push_data        = {s2_meta, s1_addr_q};
        cnt_data_d       = cnt_data_q;
        cnt_par_d        = cnt_par_q;
        cnt_unc_d        = cnt_unc_q;
        irq_d            = irq_q;
        if (s2_event) begin
            case (s2_class)
                DATA_CORR: cnt_data_d = sat_inc(cnt_data_q);
                PAR_CORR:  cnt_par_d  = sat_inc(cnt_par_q);
                default:   cnt_unc_d  = sat_inc(cnt_unc_q);
            endcase
        end
        // Extra bit keeps the sum exact even with both counters saturated.
        corr_sum = {1'b0, cnt_data_d} + {1'b0, cnt_par_d};
        if (s2_event && (s2_class == UNCORR || corr_sum >= (CNT_W+1)'(IRQ_THRESH)))
            irq_d = 1'b1;
        // A full log only has room this cycle if software pops the head.
        ovf_d = ovf_q || (s2_event && fifo_full && !log_rd_en);
    end

    // Pipeline, counter and flag registers; clr acts exactly like rst.
    always_ff @(posedge clk) begin
        if (sync_clr) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_syn_q   <= '0;
            s1_data_q  <= '0;
            cnt_data_q <= '0;
            cnt_par_q  <= '0;
            cnt_unc_q  <= '0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s1_syn_q   <= s1_syn_d;
            s1_data_q  <= s1_data_d;
            cnt_data_q <= cnt_data_d;
            cnt_par_q  <= cnt_par_d;
            cnt_unc_q  <= cnt_unc_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
        end
    end

    ecc_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk       (clk),
        .rst       (sync_clr),
        .push      (s2_event),
        .push_data (push_data),
        .pop       (log_rd_en),
        .full      (fifo_full),
        .empty     (log_empty),
        .count     (log_count),
        .head      (log_entry)
    );

    assign cnt_data_corr = cnt_data_q;
    assign cnt_par_corr  = cnt_par_q;
    assign cnt_uncorr    = cnt_unc_q;
    assign log_overflow  = ovf_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_ecc_error_logger.sv
// Self-checking bench for ecc_error_logger: directed vectors, a queue-based
// reference model compared every cycle, and literal expectations.
module tb_ecc_error_logger;

    localparam int ADDR_W     = 10;
    localparam int LOG_DEPTH  = 8;
    localparam int CNT_W      = 16;
    localparam int IRQ_THRESH = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 chk_valid;
    logic [ADDR_W-1:0]    chk_addr;
    logic [3:0]           chk_syndrome;
    logic [7:0]           chk_data;
    logic                 clr;
    logic                 log_rd_en;
    logic                 log_empty;
    logic [3:0]           log_count;
    logic [ADDR_W+13:0]   log_entry;
    logic                 log_overflow;
    logic [CNT_W-1:0]     cnt_data_corr;
    logic [CNT_W-1:0]     cnt_par_corr;
    logic [CNT_W-1:0]     cnt_uncorr;
    logic                 irq;

    int checks = 0;
    int errors = 0;

    ecc_error_logger #(
        .ADDR_W     (ADDR_W),
        .LOG_DEPTH  (LOG_DEPTH),
        .CNT_W      (CNT_W),
        .IRQ_THRESH (IRQ_THRESH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .chk_valid     (chk_valid),
        .chk_addr      (chk_addr),
        .chk_syndrome  (chk_syndrome),
        .chk_data      (chk_data),
        .clr           (clr),
        .log_rd_en     (log_rd_en),
        .log_empty     (log_empty),
        .log_count     (log_count),
        .log_entry     (log_entry),
        .log_overflow  (log_overflow),
        .cnt_data_corr (cnt_data_corr),
        .cnt_par_corr  (cnt_par_corr),
        .cnt_uncorr    (cnt_uncorr),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [23:0]       m_log[$];
    int                m_data, m_par, m_unc;
    bit                m_irq, m_ovf, model_on;
    bit                p_valid;
    logic [ADDR_W-1:0] p_addr;
    logic [3:0]        p_syn;
    logic [7:0]        p_data;
    bit                m_full, m_popped;
    logic [1:0]        m_cls;

    function automatic logic [1:0] class_of(input logic [3:0] s);
        if (s == 4'd0)                      return 2'b00;
        if (s inside {4'd1, 4'd2, 4'd4, 4'd8}) return 2'b10;
        if (s inside {4'd13, 4'd14, 4'd15})    return 2'b11;
        return 2'b01;
    endfunction

    function automatic int sat(input int v);
        return (v == CNT_MAX) ? v : v + 1;
    endfunction

    // An accepted event takes effect one edge after it was sampled.
    always @(posedge clk) begin
        if (rst || clr) begin
            m_log.delete();
            m_data = 0; m_par = 0; m_unc = 0;
            m_irq = 0; m_ovf = 0; p_valid = 0;
            if (rst) model_on = 1;
        end else begin
            m_full   = (m_log.size() == LOG_DEPTH);
            m_popped = 0;
            if (log_rd_en && m_log.size() > 0) begin
                void'(m_log.pop_front());
                m_popped = 1;
            end
            if (p_valid) begin
                m_cls = class_of(p_syn);
                if (m_cls != 2'b00) begin
                    if (m_cls == 2'b01) m_data = sat(m_data);
                    if (m_cls == 2'b10) m_par  = sat(m_par);
                    if (m_cls == 2'b11) m_unc  = sat(m_unc);
                    if (m_full && !m_popped) m_ovf = 1;
                    else m_log.push_back({m_cls, p_syn, p_data, p_addr});
                    if (m_cls == 2'b11 || (m_data + m_par) >= IRQ_THRESH) m_irq = 1;
                end
            end
            p_valid = chk_valid;
            p_addr  = chk_addr;
            p_syn   = chk_syndrome;
            p_data  = chk_data;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("cnt_data_corr", 32'(cnt_data_corr), 32'(m_data));
            check("cnt_par_corr",  32'(cnt_par_corr),  32'(m_par));
            check("cnt_uncorr",    32'(cnt_uncorr),    32'(m_unc));
            check("irq",           32'(irq),           32'(m_irq));
            check("log_overflow",  32'(log_overflow),  32'(m_ovf));
            check("log_count",     32'(log_count),     32'(m_log.size()));
            check("log_empty",     32'(log_empty),     32'(m_log.size() == 0));
            check("log_entry",     32'(log_entry),     (m_log.size() == 0) ? 32'h0 : 32'(m_log[0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input logic [ADDR_W-1:0] a, input logic [3:0] s,
                        input logic [7:0] d, input bit rd, input bit c);
        chk_valid    = v;
        chk_addr     = a;
        chk_syndrome = s;
        chk_data     = d;
        log_rd_en    = rd;
        clr          = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 4'd0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_clr();
        step(1'b0, '0, 4'd0, 8'h00, 1'b0, 1'b1);
        idle();
    endtask

    logic [3:0] nine_syn [9] = '{4'd3, 4'd1, 4'd13, 4'd5, 4'd2, 4'd14, 4'd6, 4'd4, 4'd7};

    initial begin
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        check("reset cnt_data", 32'(cnt_data_corr), 32'd0);
        check("reset cnt_par",  32'(cnt_par_corr),  32'd0);
        check("reset cnt_unc",  32'(cnt_uncorr),    32'd0);
        check("reset empty",    32'(log_empty),     32'd1);
        check("reset count",    32'(log_count),     32'd0);
        check("reset irq",      32'(irq),           32'd0);
        check("reset ovf",      32'(log_overflow),  32'd0);
        check("reset entry",    32'(log_entry),     32'd0);

        // Single data-bit correction, then a clean word.
        step(1'b1, 10'h005, 4'b0011, 8'hB3, 1'b0, 1'b0);
        check("lat1 cnt_data", 32'(cnt_data_corr), 32'd0);
        idle();
        check("first cnt_data",  32'(cnt_data_corr), 32'd1);
        check("first count",     32'(log_count),     32'd1);
        check("first entry",     32'(log_entry),     32'h4ECC05);
        step(1'b1, 10'h006, 4'b0000, 8'h12, 1'b0, 1'b0);
        idle();
        check("clean cnt_data",  32'(cnt_data_corr), 32'd1);
        check("clean count",     32'(log_count),     32'd1);

        // Parity correction, then an uncorrectable word.
        step(1'b1, 10'h007, 4'b0001, 8'h5A, 1'b0, 1'b0);
        idle();
        check("par cnt",   32'(cnt_par_corr), 32'd1);
        check("par irq",   32'(irq),          32'd0);
        step(1'b1, 10'h008, 4'b1101, 8'hC3, 1'b0, 1'b0);
        idle();
        check("unc cnt",   32'(cnt_uncorr),   32'd1);
        check("unc irq",   32'(irq),          32'd1);
        idle();
        idle();
        check("irq sticky", 32'(irq), 32'd1);
        do_clr();
        check("clr irq",   32'(irq),          32'd0);
        check("clr count", 32'(log_count),    32'd0);

        // Threshold: the fourth corrected error raises irq.
        for (int i = 0; i < 4; i++)
            step(1'b1, 10'(9'h010 + i), 4'd6, 8'(i), 1'b0, 1'b0);
        check("thr3 cnt", 32'(cnt_data_corr), 32'd3);
        check("thr3 irq", 32'(irq),           32'd0);
        idle();
        check("thr4 cnt", 32'(cnt_data_corr), 32'd4);
        check("thr4 irq", 32'(irq),           32'd1);
        do_clr();

        // Nine events into an eight-deep log, then drain.
        for (int i = 0; i < 9; i++)
            step(1'b1, 10'(10'h100 + i), nine_syn[i], 8'(i * 17), 1'b0, 1'b0);
        idle();
        check("ovf count",    32'(log_count),     32'd8);
        check("ovf flag",     32'(log_overflow),  32'd1);
        check("ovf cnt_data", 32'(cnt_data_corr), 32'd4);
        check("ovf cnt_par",  32'(cnt_par_corr),  32'd3);
        check("ovf cnt_unc",  32'(cnt_uncorr),    32'd2);
        for (int i = 0; i < 8; i++) begin
            check("drain addr", 32'(log_entry[ADDR_W-1:0]), 32'(10'h100 + i));
            step(1'b0, '0, 4'd0, 8'h00, 1'b1, 1'b0);
        end
        check("drained empty", 32'(log_empty), 32'd1);
        step(1'b0, '0, 4'd0, 8'h00, 1'b1, 1'b0);
        check("extra pop count", 32'(log_count), 32'd0);
        check("extra pop empty", 32'(log_empty), 32'd1);
        do_clr();

        // Full log with a simultaneous push and pop.
        for (int i = 0; i < 8; i++)
            step(1'b1, 10'(10'h200 + i), 4'd5, 8'hA0, 1'b0, 1'b0);
        step(1'b1, 10'h208, 4'd9, 8'hA8, 1'b0, 1'b0);
        check("full count", 32'(log_count), 32'd8);
        step(1'b0, '0, 4'd0, 8'h00, 1'b1, 1'b0);
        check("pushpop count", 32'(log_count),    32'd8);
        check("pushpop ovf",   32'(log_overflow), 32'd0);
        check("pushpop head",  32'(log_entry[ADDR_W-1:0]), 32'h201);
        idle();

        // clr discards both the stage-1 event and a same-cycle event.
        do_clr();
        step(1'b1, 10'h300, 4'd3, 8'h11, 1'b0, 1'b0);
        step(1'b1, 10'h301, 4'd13, 8'h22, 1'b0, 1'b1);
        idle();
        idle();
        check("clr drop cnt_data", 32'(cnt_data_corr), 32'd0);
        check("clr drop cnt_unc",  32'(cnt_uncorr),    32'd0);
        check("clr drop count",    32'(log_count),     32'd0);
        check("clr drop irq",      32'(irq),           32'd0);

        // Reset mid-operation drops the in-flight event.
        step(1'b1, 10'h310, 4'd2, 8'h33, 1'b0, 1'b0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        idle();
        check("rst drop cnt_par", 32'(cnt_par_corr), 32'd0);
        check("rst drop empty",   32'(log_empty),    32'd1);

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
